regfile_read_stage: RTL and testbench

- Read-side counterpart of the writeback select logic.
- Holds the 32-entry architectural register file and takes the single writeback port (write_num, write_data plus an enable).
- Serves two decode-stage read ports (rs, rt), with write-to-read bypass.
- Registers the operands into a valid/ready decode-to-execute pipeline slot that supports stall and flush.

---
 rtl/regfile_read_stage_if.sv | 37 +++
 rtl/regfile_read_stage.sv | 109 ++++++++++
 tb/tb_regfile_read_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regfile_read_stage_if.sv
// Decode-side, writeback and execute-side signals of the register-file read stage.
// The master drives the writeback port, the decode request and the execute handshake.
interface regfile_read_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_W  = 5
);
  logic              wb_en;
  logic [NUM_W-1:0]  write_num;
  logic [DATA_W-1:0] write_data;

  logic              id_valid;
  logic              id_ready;
  logic [NUM_W-1:0]  rs_num;
  logic [NUM_W-1:0]  rt_num;

  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [NUM_W-1:0]  ex_rs_num;
  logic [NUM_W-1:0]  ex_rt_num;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;

  modport master (
    output wb_en, write_num, write_data,
    output id_valid, rs_num, rt_num,
    output flush, ex_ready,
    input  id_ready, ex_valid, ex_rs_num, ex_rt_num, ex_rs_data, ex_rt_data
  );

  modport slave (
    input  wb_en, write_num, write_data,
    input  id_valid, rs_num, rt_num,
    input  flush, ex_ready,
    output id_ready, ex_valid, ex_rs_num, ex_rt_num, ex_rs_data, ex_rt_data
  );
endinterface

// File: rtl/regfile_read_stage.sv
// Architectural register file with write-to-read bypass, feeding a registered
// decode-to-execute slot with stall, flush and late-writeback refresh.
module regfile_read_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_read_stage_if.slave bus
);
  localparam int unsigned NumRegs = 2 ** NUM_W;

  logic [DATA_W-1:0] regs_q [NumRegs];

  logic              wb_live;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  logic              ex_valid_q,   ex_valid_d;
  logic [NUM_W-1:0]  ex_rs_num_q,  ex_rs_num_d;
  logic [NUM_W-1:0]  ex_rt_num_q,  ex_rt_num_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;

  logic id_ready;
  logic capture;

  // Writes to register 0 are architecturally void: never stored, never bypassed.
  assign wb_live = bus.wb_en && (bus.write_num != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_live) begin
      regs_q[bus.write_num] <= bus.write_data;
    end
  end

  always_comb begin
    rs_data = (bus.rs_num == '0) ? '0 : regs_q[bus.rs_num];
    if (wb_live && (bus.write_num == bus.rs_num)) begin
      rs_data = bus.write_data;
    end
  end

  always_comb begin
    rt_data = (bus.rt_num == '0) ? '0 : regs_q[bus.rt_num];
    if (wb_live && (bus.write_num == bus.rt_num)) begin
      rt_data = bus.write_data;
    end
  end

  assign id_ready = !ex_valid_q || bus.ex_ready;
  assign capture  = bus.id_valid && id_ready;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_rs_num_d  = ex_rs_num_q;
    ex_rt_num_d  = ex_rt_num_q;
    ex_rs_data_d = ex_rs_data_q;
    ex_rt_data_d = ex_rt_data_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (capture) begin
      ex_valid_d   = 1'b1;
      ex_rs_num_d  = bus.rs_num;
      ex_rt_num_d  = bus.rt_num;
      ex_rs_data_d = rs_data;
      ex_rt_data_d = rt_data;
    end else if (ex_valid_q) begin
      if (bus.ex_ready) begin
        ex_valid_d = 1'b0;
      end
      // Keep held operands coherent with writebacks landing after capture.
      if (wb_live && (bus.write_num == ex_rs_num_q)) begin
        ex_rs_data_d = bus.write_data;
      end
      if (wb_live && (bus.write_num == ex_rt_num_q)) begin
        ex_rt_data_d = bus.write_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_rs_num_q  <= '0;
      ex_rt_num_q  <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_rs_num_q  <= ex_rs_num_d;
      ex_rt_num_q  <= ex_rt_num_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
    end
  end

  assign bus.id_ready   = id_ready;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_rs_num  = ex_rs_num_q;
  assign bus.ex_rt_num  = ex_rt_num_q;
  assign bus.ex_rs_data = ex_rs_data_q;
  assign bus.ex_rt_data = ex_rt_data_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed bench for regfile_read_stage: reset, write/read, bypass, stall refresh,
// flush priority and back-to-back throughput against hand-computed values.
module tb_regfile_read_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  regfile_read_stage_if #(.DATA_W(32), .NUM_W(5)) bus ();

  regfile_read_stage #(
    .DATA_W(32),
    .NUM_W (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] num, input logic [31:0] data);
    bus.wb_en      = 1'b1;
    bus.write_num  = num;
    bus.write_data = data;
    step();
    bus.wb_en      = 1'b0;
  endtask

  task automatic offer(input logic [4:0] rs, input logic [4:0] rt);
    bus.id_valid = 1'b1;
    bus.rs_num   = rs;
    bus.rt_num   = rt;
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.wb_en      = 1'b0;
    bus.write_num  = '0;
    bus.write_data = '0;
    bus.id_valid   = 1'b0;
    bus.rs_num     = '0;
    bus.rt_num     = '0;
    bus.flush      = 1'b0;
    bus.ex_ready   = 1'b1;
    #1;
    check("reset_valid", 32'(bus.ex_valid), 32'd0);
    check("reset_ready", 32'(bus.id_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Write then read
    wr(5'd3, 32'hDEADBEEF);
    offer(5'd3, 5'd0);
    step();
    bus.id_valid = 1'b0;
    check("wr_rd_valid", 32'(bus.ex_valid), 32'd1);
    check("wr_rd_rs", bus.ex_rs_data, 32'hDEADBEEF);
    check("wr_rd_rt", bus.ex_rt_data, 32'h0);
    check("wr_rd_rsnum", 32'(bus.ex_rs_num), 32'd3);
    step();
    check("drain_valid", 32'(bus.ex_valid), 32'd0);

    // Same-cycle bypass on both ports
    bus.wb_en      = 1'b1;
    bus.write_num  = 5'd7;
    bus.write_data = 32'h12345678;
    offer(5'd7, 5'd7);
    #1;
    check("byp_id_ready", 32'(bus.id_ready), 32'd1);
    step();
    check("byp_rs", bus.ex_rs_data, 32'h12345678);
    check("byp_rt", bus.ex_rt_data, 32'h12345678);
    // Register 0 write is dropped; rt reads the now-stored reg7
    bus.write_num  = 5'd0;
    bus.write_data = 32'hFFFFFFFF;
    offer(5'd0, 5'd7);
    step();
    bus.wb_en    = 1'b0;
    bus.id_valid = 1'b0;
    check("byp0_rs", bus.ex_rs_data, 32'h0);
    check("byp0_rt", bus.ex_rt_data, 32'h12345678);
    step();

    // Stall with refresh
    wr(5'd9, 32'h11);
    bus.ex_ready = 1'b0;
    offer(5'd9, 5'd3);
    step();
    check("stall_cap_rs", bus.ex_rs_data, 32'h11);
    check("stall_id_ready", 32'(bus.id_ready), 32'd0);
    offer(5'd1, 5'd1);
    step();
    check("stall1_valid", 32'(bus.ex_valid), 32'd1);
    check("stall1_rsnum", 32'(bus.ex_rs_num), 32'd9);
    wr(5'd9, 32'h22);
    check("refresh_rs", bus.ex_rs_data, 32'h22);
    check("refresh_rt", bus.ex_rt_data, 32'hDEADBEEF);
    check("refresh_id_ready", 32'(bus.id_ready), 32'd0);
    check("refresh_valid", 32'(bus.ex_valid), 32'd1);
    bus.id_valid = 1'b0;

    // Asynchronous reset mid-stall
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ex_valid), 32'd0);
    check("arst_rs", bus.ex_rs_data, 32'h0);
    check("arst_rt", bus.ex_rt_data, 32'h0);
    check("arst_rsnum", 32'(bus.ex_rs_num), 32'd0);
    step();
    rst_n        = 1'b1;
    bus.ex_ready = 1'b1;
    offer(5'd5, 5'd9);
    step();
    bus.id_valid = 1'b0;
    check("post_rst_rs5", bus.ex_rs_data, 32'h0);
    check("post_rst_rt9", bus.ex_rt_data, 32'h0);
    step();

    // Flush beats a simultaneous capture
    wr(5'd3, 32'h33);
    offer(5'd3, 5'd0);
    step();
    check("flush_pre_valid", 32'(bus.ex_valid), 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.id_valid = 1'b0;
    check("flush_valid", 32'(bus.ex_valid), 32'd0);
    offer(5'd3, 5'd0);
    step();
    bus.id_valid = 1'b0;
    check("post_flush_valid", 32'(bus.ex_valid), 32'd1);
    check("post_flush_rs", bus.ex_rs_data, 32'h33);
    step();

    // Back-to-back throughput
    for (int i = 1; i <= 4; i++) begin
      wr(5'(i), 32'hA0 + 32'(i));
    end
    for (int i = 1; i <= 4; i++) begin
      offer(5'(i), 5'd0);
      step();
      check($sformatf("b2b_valid%0d", i), 32'(bus.ex_valid), 32'd1);
      check($sformatf("b2b_rs%0d", i), bus.ex_rs_data, 32'hA0 + 32'(i));
    end
    bus.id_valid = 1'b0;
    step();
    check("b2b_drain", 32'(bus.ex_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
